// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing generator driven by a pixel-tick enable.
// Produces hsync/vsync, the visible-area flag, pixel coordinates and
// line/frame start strobes. All outputs come straight from registers.
// Optional feature macro: VGA_TIMING_FRAME_CNT_EN adds an 8-bit frame counter
// output (frame_cnt_o). With the macro undefined the port is absent.
module vga_timing_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic SYNC_POL = 1'b0,
    parameter int   COORD_W  = 10
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               en_i,
    output logic               hsync_o,
    output logic               vsync_o,
    output logic               inActiveArea_o,
    output logic [COORD_W-1:0] pixel_x_o,
    output logic [COORD_W-1:0] pixel_y_o,
    output logic               line_start_o,
    output logic               frame_start_o
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [7:0]         frame_cnt_o
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [COORD_W-1:0] H_LAST       = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST       = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_ACT_END    = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_ACT_END    = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] H_SYNC_BEG   = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] H_SYNC_END   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [COORD_W-1:0] V_SYNC_BEG   = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] V_SYNC_END   = COORD_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [COORD_W-1:0] COORD_ZERO   = {COORD_W{1'b0}};
    localparam logic [COORD_W-1:0] COORD_ONE    = COORD_W'(1);

    // Half-open window test used by both sync decoders: lo <= val < hi
    function automatic logic in_window(
        input logic [COORD_W-1:0] val,
        input logic [COORD_W-1:0] lo,
        input logic [COORD_W-1:0] hi
    );
        return (val >= lo) && (val < hi);
    endfunction

    // Counter and output registers
    logic [COORD_W-1:0] r_h_cnt;
    logic [COORD_W-1:0] r_v_cnt;
    logic               r_active;
    logic               r_hsync;
    logic               r_vsync;
    logic               r_line_start;
    logic               r_frame_start;

    // Combinational next-state values
    logic               w_h_last;
    logic               w_v_last;
    logic [COORD_W-1:0] w_h_nxt;
    logic [COORD_W-1:0] w_v_nxt;
    logic               w_line_wrap;
    logic               w_frame_wrap;
    logic               w_active_nxt;
    logic               w_hsync_nxt;
    logic               w_vsync_nxt;

    assign w_h_last = (r_h_cnt == H_LAST);
    assign w_v_last = (r_v_cnt == V_LAST);

    // Advance the raster position on a pixel tick; wrap at line and frame ends
    always_comb begin
        w_h_nxt      = r_h_cnt;
        w_v_nxt      = r_v_cnt;
        w_line_wrap  = 1'b0;
        w_frame_wrap = 1'b0;
        if (en_i) begin
            if (w_h_last) begin
                w_h_nxt     = COORD_ZERO;
                w_line_wrap = 1'b1;
                if (w_v_last) begin
                    w_v_nxt      = COORD_ZERO;
                    w_frame_wrap = 1'b1;
                end else begin
                    w_v_nxt = r_v_cnt + COORD_ONE;
                end
            end else begin
                w_h_nxt = r_h_cnt + COORD_ONE;
            end
        end else begin
            w_h_nxt = r_h_cnt;
            w_v_nxt = r_v_cnt;
        end
    end

    // Decode level outputs from the next position so they line up with the counters
    always_comb begin
        w_active_nxt = (w_h_nxt < H_ACT_END) && (w_v_nxt < V_ACT_END);
        w_hsync_nxt  = in_window(w_h_nxt, H_SYNC_BEG, H_SYNC_END) ? SYNC_POL : ~SYNC_POL;
        w_vsync_nxt  = in_window(w_v_nxt, V_SYNC_BEG, V_SYNC_END) ? SYNC_POL : ~SYNC_POL;
    end

    // State and output registers; reset parks at the last pixel so the first tick lands on (0,0)
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_h_cnt       <= H_LAST;
            r_v_cnt       <= V_LAST;
            r_active      <= 1'b0;
            r_hsync       <= ~SYNC_POL;
            r_vsync       <= ~SYNC_POL;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_h_cnt       <= w_h_nxt;
            r_v_cnt       <= w_v_nxt;
            r_active      <= w_active_nxt;
            r_hsync       <= w_hsync_nxt;
            r_vsync       <= w_vsync_nxt;
            r_line_start  <= w_line_wrap;
            r_frame_start <= w_frame_wrap;
        end
    end

    assign pixel_x_o      = r_h_cnt;
    assign pixel_y_o      = r_v_cnt;
    assign inActiveArea_o = r_active;
    assign hsync_o        = r_hsync;
    assign vsync_o        = r_vsync;
    assign line_start_o   = r_line_start;
    assign frame_start_o  = r_frame_start;

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [7:0] r_frame_cnt;

    // Count frames started since reset; steps on the same edge that raises frame_start_o
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_frame_cnt <= 8'd0;
        end else if (w_frame_wrap) begin
            r_frame_cnt <= r_frame_cnt + 8'd1;
        end else begin
            r_frame_cnt <= r_frame_cnt;
        end
    end

    assign frame_cnt_o = r_frame_cnt;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen. Two instances share clock, reset and
// enable: one with the default 640x480 timing and one with a tiny raster and
// active-high sync so whole frames can be covered in a short run. Expected
// values come from the number of pixel ticks since reset, using plain
// modular arithmetic on the linear raster index.
module tb_vga_timing_gen;

    // Small raster for instance B: 16 x 12 = 192 ticks per frame
    localparam int B_HA  = 8;
    localparam int B_HFP = 2;
    localparam int B_HS  = 3;
    localparam int B_HBP = 3;
    localparam int B_VA  = 6;
    localparam int B_VFP = 2;
    localparam int B_VS  = 2;
    localparam int B_VBP = 2;

    logic clk = 1'b0;
    logic rst_n;
    logic en;

    logic       a_hs, a_vs, a_act, a_ls, a_fs;
    logic [9:0] a_x, a_y;
    logic       b_hs, b_vs, b_act, b_ls, b_fs;
    logic [9:0] b_x, b_y;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [7:0] a_fc, b_fc;
`endif

    int n_errors = 0;
    int n_checks = 0;

    // Reference state: pixel ticks since reset, and whether the last edge was a tick
    longint ticks     = 0;
    logic   last_tick = 1'b0;

    always #5 clk = ~clk;

    vga_timing_gen u_dut_a (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .en_i           (en),
        .hsync_o        (a_hs),
        .vsync_o        (a_vs),
        .inActiveArea_o (a_act),
        .pixel_x_o      (a_x),
        .pixel_y_o      (a_y),
        .line_start_o   (a_ls),
        .frame_start_o  (a_fs)
`ifdef VGA_TIMING_FRAME_CNT_EN
        ,
        .frame_cnt_o    (a_fc)
`endif
    );

    vga_timing_gen #(
        .H_ACTIVE (B_HA),
        .H_FP     (B_HFP),
        .H_SYNC   (B_HS),
        .H_BP     (B_HBP),
        .V_ACTIVE (B_VA),
        .V_FP     (B_VFP),
        .V_SYNC   (B_VS),
        .V_BP     (B_VBP),
        .SYNC_POL (1'b1),
        .COORD_W  (10)
    ) u_dut_b (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .en_i           (en),
        .hsync_o        (b_hs),
        .vsync_o        (b_vs),
        .inActiveArea_o (b_act),
        .pixel_x_o      (b_x),
        .pixel_y_o      (b_y),
        .line_start_o   (b_ls),
        .frame_start_o  (b_fs)
`ifdef VGA_TIMING_FRAME_CNT_EN
        ,
        .frame_cnt_o    (b_fc)
`endif
    );

    // Single comparison point: counts every check and reports any mismatch
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (tick %0d, t=%0t)", tag, obs, exp, ticks, $time);
        end
    endtask

    // Compare one instance against the raster position implied by the tick count
    task automatic check_inst(
        input string nm,
        input int ha, input int hfp, input int hs, input int hbp,
        input int va, input int vfp, input int vs, input int vbp,
        input logic pol,
        input logic [9:0] x, input logic [9:0] y,
        input logic act, input logic hsy, input logic vsy,
        input logic ls, input logic fs
    );
        int     ht, vt, h, v;
        longint f, idx;
        logic   e_act, e_hs, e_vs;
        ht  = ha + hfp + hs + hbp;
        vt  = va + vfp + vs + vbp;
        f   = longint'(ht) * longint'(vt);
        idx = (f - 1 + ticks) % f;
        h   = int'(idx % ht);
        v   = int'(idx / ht);
        e_act = (h < ha) && (v < va);
        e_hs  = ((h >= ha + hfp) && (h < ha + hfp + hs)) ? pol : ~pol;
        e_vs  = ((v >= va + vfp) && (v < va + vfp + vs)) ? pol : ~pol;
        chk({nm, ".x"},           32'(x),   32'(h));
        chk({nm, ".y"},           32'(y),   32'(v));
        chk({nm, ".active"},      32'(act), 32'(e_act));
        chk({nm, ".hsync"},       32'(hsy), 32'(e_hs));
        chk({nm, ".vsync"},       32'(vsy), 32'(e_vs));
        chk({nm, ".line_start"},  32'(ls),  32'(last_tick && (h == 0)));
        chk({nm, ".frame_start"}, 32'(fs),  32'(last_tick && (idx == 0)));
    endtask

    task automatic check_all();
`ifdef VGA_TIMING_FRAME_CNT_EN
        longint fa, fb;
`endif
        check_inst("a", 640, 16, 96, 48, 480, 10, 2, 33, 1'b0,
                   a_x, a_y, a_act, a_hs, a_vs, a_ls, a_fs);
        check_inst("b", B_HA, B_HFP, B_HS, B_HBP, B_VA, B_VFP, B_VS, B_VBP, 1'b1,
                   b_x, b_y, b_act, b_hs, b_vs, b_ls, b_fs);
`ifdef VGA_TIMING_FRAME_CNT_EN
        fa = 800 * 525;
        fb = longint'(B_HA + B_HFP + B_HS + B_HBP) * longint'(B_VA + B_VFP + B_VS + B_VBP);
        chk("a.frame_cnt", 32'(a_fc), 32'(((ticks + fa - 1) / fa) % 256));
        chk("b.frame_cnt", 32'(b_fc), 32'(((ticks + fb - 1) / fb) % 256));
`endif
    endtask

    // One clock: apply enable, let the edge happen, update the model, check just after
    task automatic step(input logic en_v);
        en = en_v;
        @(posedge clk);
        if (en_v) begin
            ticks++;
        end
        last_tick = en_v;
        #1;
        check_all();
    endtask

    // Assert reset between clock edges and check the outputs before any edge arrives
    task automatic async_reset();
        en = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        ticks     = 0;
        last_tick = 1'b0;
        check_all();
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int stop_at;
        rst_n = 1'b0;
        en    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // First ticks after release: (0,0) with both strobes, then strobes drop
        step(1'b1);
        step(1'b1);
        step(1'b0);

        // Random pixel-tick pattern
        for (int i = 0; i < 2500; i++) begin
            step(($urandom_range(3, 0) != 0) ? 1'b1 : 1'b0);
        end

        // Asynchronous reset at a random point mid-frame, then restart
        stop_at = $urandom_range(150, 20);
        for (int i = 0; i < stop_at; i++) begin
            step(1'b1);
        end
        async_reset();
        step(1'b1);
        step(1'b1);

        // Enable one clock in four
        for (int i = 0; i < 400; i++) begin
            step((i % 4) == 0 ? 1'b1 : 1'b0);
        end

        // Free run long enough for instance B to wrap its frame count past 255
        for (int i = 0; i < 260 * 192; i++) begin
            step(1'b1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
